control_sequencer: RTL and testbench

//  Microcoded control unit for the 8-bit CPU. Directly upstream of the program counter and the

---
 rtl/cpu_pkg.sv | 45 ++++
 rtl/microcode_rom.sv | 95 +++++++++
 rtl/control_sequencer.sv | 82 ++++++++
 tb/tb_control_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types for the 8-bit CPU control path
package cpu_pkg;

    localparam int FETCH_STEPS = 2;

    // Field order is MSB-first: hlt is bit 15, flags_in is bit 0.
    typedef struct packed {
        logic hlt;
        logic mar_in;
        logic ram_in;
        logic ram_out;
        logic ir_in;
        logic ir_out;
        logic a_in;
        logic a_out;
        logic b_in;
        logic alu_out;
        logic alu_sub;
        logic out_in;
        logic pc_inc;
        logic pc_out;
        logic pc_jump;
        logic flags_in;
    } ctrl_t;

    typedef enum logic [3:0] {
        NOP = 4'h0,
        LDA = 4'h1,
        ADD = 4'h2,
        SUB = 4'h3,
        STA = 4'h4,
        LDI = 4'h5,
        JMP = 4'h6,
        JC  = 4'h7,
        JZ  = 4'h8,
        OUT = 4'hE,
        HLT = 4'hF
    } opcode_e;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

endpackage

// File: rtl/microcode_rom.sv
// rtl/microcode_rom.sv - combinational microcode: {opcode, step, flags} -> control word and done
module microcode_rom
    import cpu_pkg::*;
#(
    parameter int STEP_W = 3
) (
    input  logic [3:0]        opcode_i,
    input  logic [STEP_W-1:0] step_i,
    input  logic              flag_c_i,
    input  logic              flag_z_i,
    output ctrl_t             ctrl_o,
    output logic              done_o
);

    always_comb begin
        ctrl_o = '0;
        done_o = 1'b0;
        case (step_i)
            STEP_W'(0): begin
                ctrl_o.pc_out = 1'b1;
                ctrl_o.mar_in = 1'b1;
            end
            STEP_W'(1): begin
                ctrl_o.ram_out = 1'b1;
                ctrl_o.ir_in   = 1'b1;
                ctrl_o.pc_inc  = 1'b1;
                done_o = (opcode_i == NOP) || (opcode_i >= 4'h9 && opcode_i <= 4'hD);
            end
            STEP_W'(2): begin
                done_o = 1'b1;
                case (opcode_i)
                    LDA, ADD, SUB, STA: begin
                        ctrl_o.ir_out = 1'b1;
                        ctrl_o.mar_in = 1'b1;
                        done_o = 1'b0;
                    end
                    LDI: begin
                        ctrl_o.ir_out = 1'b1;
                        ctrl_o.a_in   = 1'b1;
                    end
                    JMP: begin
                        ctrl_o.ir_out  = 1'b1;
                        ctrl_o.pc_jump = 1'b1;
                    end
                    // Untaken conditional jumps leave T2 empty but still end the instruction.
                    JC: begin
                        ctrl_o.ir_out  = flag_c_i;
                        ctrl_o.pc_jump = flag_c_i;
                    end
                    JZ: begin
                        ctrl_o.ir_out  = flag_z_i;
                        ctrl_o.pc_jump = flag_z_i;
                    end
                    OUT: begin
                        ctrl_o.a_out  = 1'b1;
                        ctrl_o.out_in = 1'b1;
                    end
                    HLT: ctrl_o.hlt = 1'b1;
                    default: ;
                endcase
            end
            STEP_W'(3): begin
                done_o = 1'b1;
                case (opcode_i)
                    LDA: begin
                        ctrl_o.ram_out = 1'b1;
                        ctrl_o.a_in    = 1'b1;
                    end
                    ADD, SUB: begin
                        ctrl_o.ram_out = 1'b1;
                        ctrl_o.b_in    = 1'b1;
                        ctrl_o.alu_sub = (opcode_i == SUB);
                        done_o = 1'b0;
                    end
                    STA: begin
                        ctrl_o.a_out  = 1'b1;
                        ctrl_o.ram_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            STEP_W'(4): begin
                done_o = 1'b1;
                if (opcode_i == ADD || opcode_i == SUB) begin
                    ctrl_o.alu_out  = 1'b1;
                    ctrl_o.a_in     = 1'b1;
                    ctrl_o.flags_in = 1'b1;
                    ctrl_o.alu_sub  = (opcode_i == SUB);
                end
            end
            default: done_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - T-step counter, RUN/HALT FSM and control-word gating
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int MAX_STEPS = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         step_en,
    input  logic [3:0]                   opcode,
    input  logic                         flag_c,
    input  logic                         flag_z,
    output ctrl_t                        ctrl,
    output logic [$clog2(MAX_STEPS)-1:0] step,
    output logic                         halted
);

    localparam int STEP_W = $clog2(MAX_STEPS);

    state_e              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    ctrl_t               rom_ctrl;
    logic                rom_done;

    microcode_rom #(.STEP_W(STEP_W)) u_rom (
        .opcode_i (opcode),
        .step_i   (step_q),
        .flag_c_i (flag_c),
        .flag_z_i (flag_z),
        .ctrl_o   (rom_ctrl),
        .done_o   (rom_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        ctrl    = '0;
        case (state_q)
            RUN: begin
                ctrl = rom_ctrl;
                if (step_en) begin
                    if (rom_done || step_q == STEP_W'(MAX_STEPS - 1))
                        step_d = '0;
                    else
                        step_d = step_q + STEP_W'(1);
                    if (step_q == STEP_W'(FETCH_STEPS) && opcode == HLT)
                        state_d = HALT;
                end
            end
            HALT: begin
                ctrl.hlt = 1'b1;
                step_d   = '0;
            end
            default: state_d = RUN;
        endcase
        // Bus agents must see a quiet control word for the whole reset pulse.
        if (rst)
            ctrl = '0;
    end

    assign step   = step_q;
    assign halted = (state_q == HALT);

    always @(posedge clk) begin
        if (!rst) begin
            assert (!(ctrl.pc_inc && ctrl.pc_jump));
            assert ($countones({ctrl.ram_out, ctrl.ir_out, ctrl.a_out,
                                ctrl.alu_out, ctrl.pc_out}) <= 1);
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed self-checking bench for control_sequencer
module tb_control_sequencer;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       step_en = 1'b1;
    logic [3:0] opcode = 4'h1;
    logic       flag_c = 1'b0;
    logic       flag_z = 1'b0;
    ctrl_t      ctrl;
    logic [2:0] step;
    logic       halted;

    int vectors = 0;
    int miscompares = 0;
    int pc_inc_seen;

    localparam logic [15:0] C_T0      = 16'h4004;
    localparam logic [15:0] C_T1      = 16'h1808;
    localparam logic [15:0] C_ADDR    = 16'h4400;
    localparam logic [15:0] C_LDA_T3  = 16'h1200;
    localparam logic [15:0] C_ADD_T3  = 16'h1080;
    localparam logic [15:0] C_ADD_T4  = 16'h0241;
    localparam logic [15:0] C_SUB_T3  = 16'h10A0;
    localparam logic [15:0] C_SUB_T4  = 16'h0261;
    localparam logic [15:0] C_JUMP    = 16'h0402;
    localparam logic [15:0] C_HLT     = 16'h8000;

    control_sequencer dut (
        .clk     (clk),
        .rst     (rst),
        .step_en (step_en),
        .opcode  (opcode),
        .flag_c  (flag_c),
        .flag_z  (flag_z),
        .ctrl    (ctrl),
        .step    (step),
        .halted  (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input logic [2:0] s, input logic [15:0] c);
        check({tag, ".step"}, 16'(step), 16'(s));
        check({tag, ".ctrl"}, ctrl, c);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst.ctrl", ctrl, 16'h0000);
        tick();
        rst = 1'b0;
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            vectors++;
            assert (!(ctrl.pc_inc && ctrl.pc_jump)) else begin
                miscompares++;
                $error("FAIL inv_pc: observed inc=%b jump=%b expected not both", ctrl.pc_inc, ctrl.pc_jump);
            end
        end
    end

    initial begin
        logic [2:0]  add_steps [6];
        logic [15:0] add_ctrls [6];
        logic [15:0] sub_ctrls [6];
        add_steps = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        add_ctrls = '{C_T0, C_T1, C_ADDR, C_ADD_T3, C_ADD_T4, C_T0};
        sub_ctrls = '{C_T0, C_T1, C_ADDR, C_SUB_T3, C_SUB_T4, C_T0};

        // 1: reset and LDA fetch
        #1;
        check("reset.ctrl0", ctrl, 16'h0000);
        tick();
        tick();
        check("reset.ctrl", ctrl, 16'h0000);
        check("reset.step", 16'(step), 16'h0);
        check("reset.halted", 16'(halted), 16'h0);
        rst = 1'b0;
        #1;
        expect_state("lda.t0", 3'd0, C_T0);
        tick();
        expect_state("lda.t1", 3'd1, C_T1);
        tick();
        expect_state("lda.t2", 3'd2, C_ADDR);

        // 2: ADD full run, then SUB
        do_reset();
        opcode = 4'h2;
        #1;
        pc_inc_seen = 0;
        for (int i = 0; i < 6; i++) begin
            expect_state($sformatf("add.%0d", i), add_steps[i], add_ctrls[i]);
            if (i < 5 && ctrl.pc_inc) pc_inc_seen++;
            tick();
        end
        check("add.pc_inc_once", 16'(pc_inc_seen), 16'd1);
        opcode = 4'h3;
        #1;
        for (int i = 1; i < 6; i++) begin
            expect_state($sformatf("sub.%0d", i), add_steps[i], sub_ctrls[i]);
            tick();
        end

        // 3: JC not taken then taken, plus flag change while stalled
        do_reset();
        opcode = 4'h7;
        flag_c = 1'b0;
        tick();
        tick();
        expect_state("jc0.t2", 3'd2, 16'h0000);
        tick();
        expect_state("jc0.next", 3'd0, C_T0);
        flag_c = 1'b1;
        tick();
        tick();
        expect_state("jc1.t2", 3'd2, C_JUMP);
        step_en = 1'b0;
        flag_c = 1'b0;
        #1;
        check("jc.stall_flag0", ctrl, 16'h0000);
        flag_c = 1'b1;
        #1;
        check("jc.stall_flag1", ctrl, C_JUMP);
        step_en = 1'b1;
        tick();
        expect_state("jc1.next", 3'd0, C_T0);

        // 4: NOP and unused opcode skip the execute phase
        opcode = 4'h0;
        tick();
        expect_state("nop.t1", 3'd1, C_T1);
        tick();
        expect_state("nop.next", 3'd0, C_T0);
        opcode = 4'hB;
        tick();
        expect_state("op_b.t1", 3'd1, C_T1);
        tick();
        expect_state("op_b.next", 3'd0, C_T0);

        // 5: HLT freezes until reset
        opcode = 4'hF;
        tick();
        tick();
        expect_state("hlt.t2", 3'd2, C_HLT);
        check("hlt.t2.halted", 16'(halted), 16'h0);
        tick();
        expect_state("hlt.frozen", 3'd0, C_HLT);
        check("hlt.halted", 16'(halted), 16'h1);
        opcode = 4'h2;
        tick();
        tick();
        tick();
        expect_state("hlt.stays", 3'd0, C_HLT);
        check("hlt.stays.halted", 16'(halted), 16'h1);
        do_reset();
        check("hlt.cleared", 16'(halted), 16'h0);
        expect_state("hlt.after_rst", 3'd0, C_T0);

        // 6: LDA with step_en stalls, reset mid-instruction
        opcode = 4'h1;
        step_en = 1'b1;
        tick();
        expect_state("stall.t1", 3'd1, C_T1);
        step_en = 1'b0;
        tick();
        expect_state("stall.hold1", 3'd1, C_T1);
        tick();
        expect_state("stall.hold2", 3'd1, C_T1);
        step_en = 1'b1;
        tick();
        expect_state("stall.t2", 3'd2, C_ADDR);
        tick();
        expect_state("stall.t3", 3'd3, C_LDA_T3);
        rst = 1'b1;
        #1;
        expect_state("midrst", 3'd0, 16'h0000);
        tick();
        rst = 1'b0;
        #1;
        expect_state("midrst.release", 3'd0, C_T0);
        tick();
        expect_state("midrst.t1", 3'd1, C_T1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
